// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared constants, state encoding and width helper for the TDC measurement controller
package tdc_pkg;

    localparam int TAPS_PER_CARRY = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CLEAR     = 3'd1;
    localparam logic [2:0] ST_ARMED     = 3'd2;
    localparam logic [2:0] ST_WAIT_STOP = 3'd3;
    localparam logic [2:0] ST_ENCODE    = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_CLEAR     = ST_CLEAR,
        S_ARMED     = ST_ARMED,
        S_WAIT_STOP = ST_WAIT_STOP,
        S_ENCODE    = ST_ENCODE,
        S_DONE      = ST_DONE
    } state_t;

    function automatic int fine_w(input int num);
        return $clog2(num + 1);
    endfunction

endpackage

// File: rtl/tdc_measure_ctrl_if.sv
// rtl/tdc_measure_ctrl_if.sv - result handshake between the measurement controller and readout
interface tdc_measure_ctrl_if #(
    parameter int FINE_W   = 4,
    parameter int COARSE_W = 16
);
    logic                oValid;
    logic                iReady;
    logic [FINE_W-1:0]   oStartFine;
    logic [FINE_W-1:0]   oStopFine;
    logic [COARSE_W-1:0] oCoarse;
    logic                oTimeout;

    modport master (output oValid, oStartFine, oStopFine, oCoarse, oTimeout, input iReady);
    modport slave  (input oValid, oStartFine, oStopFine, oCoarse, oTimeout, output iReady);
endinterface

// File: rtl/tdc_popcount_acc.sv
// rtl/tdc_popcount_acc.sv - one tap group popcount added to a running accumulator
module tdc_popcount_acc
    import tdc_pkg::*;
#(
    parameter int FINE_W = 4
) (
    input  logic                      clk,
    input  logic                      iRst,
    input  logic                      clr,
    input  logic                      en,
    input  logic [TAPS_PER_CARRY-1:0] grp,
    output logic [FINE_W-1:0]         sum
);
    logic [FINE_W-1:0] acc_q, acc_d;
    logic [2:0]        pop;

    assign pop = {2'b00, grp[0]} + {2'b00, grp[1]} + {2'b00, grp[2]} + {2'b00, grp[3]};
    // sum already includes the current group so the last group needs no extra cycle
    assign sum = acc_q + FINE_W'(pop);

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (iRst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/tdc_measure_ctrl.sv
// rtl/tdc_measure_ctrl.sv - sequences clear/start/stop capture on the Fine delay line and encodes tap counts
module tdc_measure_ctrl
    import tdc_pkg::*;
#(
    parameter int                  NUM        = 12,
    parameter int                  COARSE_W   = 16,
    parameter logic [COARSE_W-1:0] MAX_COARSE = 16'hFFFF,
    parameter int                  CLR_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      iRst,
    input  logic                      iArm,
    input  logic [NUM-1:0]            iFFStart,
    input  logic [NUM-1:0]            iFFStop,
    output logic                      oFineRst,
    output logic                      oStartEnable,
    output logic                      oStopEnable,
    output logic                      oBusy,
    tdc_measure_ctrl_if.master        rd
);
    localparam int FINE_W = fine_w(NUM);
    localparam int GROUPS = NUM / TAPS_PER_CARRY;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int CLR_W  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);
    localparam logic [CLR_W-1:0] LAST_CLR = CLR_W'(CLR_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic [GRP_W-1:0]    grp_q, grp_d;
    logic [COARSE_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [NUM-1:0]      start_code_q, start_code_d;
    logic [NUM-1:0]      stop_code_q, stop_code_d;
    logic                fine_rst_q, fine_rst_d;
    logic                start_en_q, start_en_d;
    logic                stop_en_q, stop_en_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [FINE_W-1:0]   start_fine_q, start_fine_d;
    logic [FINE_W-1:0]   stop_fine_q, stop_fine_d;
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic                timeout_q, timeout_d;

    logic                      acc_clr, acc_en;
    logic [TAPS_PER_CARRY-1:0] start_grp, stop_grp;
    logic [FINE_W-1:0]         start_sum, stop_sum;

    always_comb begin
        start_grp = '0;
        stop_grp  = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (grp_q == GRP_W'(g)) begin
                start_grp = start_code_q[g*TAPS_PER_CARRY +: TAPS_PER_CARRY];
                stop_grp  = ~stop_code_q[g*TAPS_PER_CARRY +: TAPS_PER_CARRY];
            end
        end
    end

    tdc_popcount_acc #(.FINE_W(FINE_W)) u_start_acc (
        .clk(clk), .iRst(iRst), .clr(acc_clr), .en(acc_en), .grp(start_grp), .sum(start_sum)
    );

    tdc_popcount_acc #(.FINE_W(FINE_W)) u_stop_acc (
        .clk(clk), .iRst(iRst), .clr(acc_clr), .en(acc_en), .grp(stop_grp), .sum(stop_sum)
    );

    // the counter holds cycles already elapsed, so the stop cycle itself adds one
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        grp_d        = grp_q;
        cnt_d        = cnt_q;
        start_code_d = start_code_q;
        stop_code_d  = stop_code_q;
        fine_rst_d   = fine_rst_q;
        start_en_d   = start_en_q;
        stop_en_d    = stop_en_q;
        valid_d      = valid_q;
        start_fine_d = start_fine_q;
        stop_fine_d  = stop_fine_q;
        coarse_d     = coarse_q;
        timeout_d    = timeout_q;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iArm) begin
                    state_d    = S_CLEAR;
                    fine_rst_d = 1'b1;
                    clr_cnt_d  = '0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == LAST_CLR) begin
                    state_d    = S_ARMED;
                    fine_rst_d = 1'b0;
                    start_en_d = 1'b1;
                    stop_en_d  = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_ARMED: begin
                if (iFFStart[0]) begin
                    state_d      = S_WAIT_STOP;
                    start_code_d = iFFStart;
                    cnt_d        = '0;
                    start_en_d   = 1'b0;
                end
            end
            S_WAIT_STOP: begin
                if (!iFFStop[0]) begin
                    state_d     = S_ENCODE;
                    stop_code_d = iFFStop;
                    coarse_d    = cnt_inc;
                    stop_en_d   = 1'b0;
                    acc_clr     = 1'b1;
                    grp_d       = '0;
                end else if (cnt_inc == MAX_COARSE) begin
                    state_d      = S_DONE;
                    timeout_d    = 1'b1;
                    coarse_d     = MAX_COARSE;
                    start_fine_d = '0;
                    stop_fine_d  = '0;
                    stop_en_d    = 1'b0;
                    valid_d      = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ENCODE: begin
                acc_en = 1'b1;
                if (grp_q == LAST_GRP) begin
                    state_d      = S_DONE;
                    start_fine_d = start_sum;
                    stop_fine_d  = stop_sum;
                    timeout_d    = 1'b0;
                    valid_d      = 1'b1;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            S_DONE: begin
                if (rd.iReady) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (iRst) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= '0;
            grp_q        <= '0;
            cnt_q        <= '0;
            start_code_q <= '0;
            stop_code_q  <= '0;
            fine_rst_q   <= 1'b0;
            start_en_q   <= 1'b0;
            stop_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            start_fine_q <= '0;
            stop_fine_q  <= '0;
            coarse_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            grp_q        <= grp_d;
            cnt_q        <= cnt_d;
            start_code_q <= start_code_d;
            stop_code_q  <= stop_code_d;
            fine_rst_q   <= fine_rst_d;
            start_en_q   <= start_en_d;
            stop_en_q    <= stop_en_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            start_fine_q <= start_fine_d;
            stop_fine_q  <= stop_fine_d;
            coarse_q     <= coarse_d;
            timeout_q    <= timeout_d;
        end
    end

    assign oFineRst      = fine_rst_q;
    assign oStartEnable  = start_en_q;
    assign oStopEnable   = stop_en_q;
    assign oBusy         = busy_q;
    assign rd.oValid     = valid_q;
    assign rd.oStartFine = start_fine_q;
    assign rd.oStopFine  = stop_fine_q;
    assign rd.oCoarse    = coarse_q;
    assign rd.oTimeout   = timeout_q;
endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// tb/tb_tdc_measure_ctrl.sv - scoreboard bench for the TDC measurement controller
module tb_tdc_measure_ctrl;
    localparam int NUM      = 12;
    localparam int COARSE_W = 16;
    localparam int FINE_W   = 4;
    localparam int MAXC     = 20;
    localparam int CLR      = 2;
    localparam int GROUPS   = NUM / 4;

    logic            clk = 1'b0;
    logic            iRst;
    logic            iArm;
    logic [NUM-1:0]  iFFStart;
    logic [NUM-1:0]  iFFStop;
    logic            oFineRst, oStartEnable, oStopEnable, oBusy;

    tdc_measure_ctrl_if #(.FINE_W(FINE_W), .COARSE_W(COARSE_W)) rd ();

    tdc_measure_ctrl #(
        .NUM(NUM), .COARSE_W(COARSE_W), .MAX_COARSE(16'd20), .CLR_CYCLES(CLR)
    ) dut (
        .clk(clk), .iRst(iRst), .iArm(iArm), .iFFStart(iFFStart), .iFFStop(iFFStop),
        .oFineRst(oFineRst), .oStartEnable(oStartEnable), .oStopEnable(oStopEnable),
        .oBusy(oBusy), .rd(rd.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int sf;
        int pf;
        int co;
        int to;
        int vcyc;
    } exp_t;
    exp_t sb[$];

    logic [2*FINE_W+COARSE_W:0] snap;
    bit in_valid = 0;
    bit stable_ok = 1;
    bit drop_pending = 0;

    always @(negedge clk) begin
        exp_t e;
        if (drop_pending) begin
            drop_pending = 0;
            check("valid_drop", rd.oValid, 0);
            check("idle_after_accept", oBusy, 0);
        end
        if (rd.oValid) begin
            if (!in_valid) begin
                in_valid  = 1;
                stable_ok = 1;
                snap = {rd.oStartFine, rd.oStopFine, rd.oCoarse, rd.oTimeout};
                if (sb.size() == 0) check("unexpected_valid", 1, 0);
                else if (sb[0].vcyc >= 0) check("valid_latency", cyc, sb[0].vcyc);
            end else if (snap !== {rd.oStartFine, rd.oStopFine, rd.oCoarse, rd.oTimeout}) begin
                stable_ok = 0;
            end
            if (rd.iReady) begin
                in_valid     = 0;
                drop_pending = 1;
                check("result_stable", stable_ok, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("start_fine", rd.oStartFine, e.sf);
                    check("stop_fine", rd.oStopFine, e.pf);
                    check("coarse", rd.oCoarse, e.co);
                    check("timeout_flag", rd.oTimeout, e.to);
                end
            end
        end
    end

    task automatic arm_and_clear();
        int hi = 0;
        int w  = 0;
        @(posedge clk); #1 iArm = 1'b1;
        @(posedge clk); #1 iArm = 1'b0;
        @(negedge clk);
        while (oFineRst && w < 50) begin
            hi++;
            w++;
            @(negedge clk);
        end
        check("fine_rst_cycles", hi, CLR);
        check("start_en_rise", oStartEnable, 1);
        check("stop_en_rise", oStopEnable, 1);
    endtask

    task automatic wait_valid();
        int w = 0;
        while (!rd.oValid && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!rd.oValid) check("valid_wait_expired", 0, 1);
    endtask

    task automatic accept(input int delay);
        repeat (delay) @(posedge clk);
        @(posedge clk); #1 rd.iReady = 1'b1; iArm = 1'b1;
        @(posedge clk); #1 rd.iReady = 1'b0; iArm = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_meas(input logic [NUM-1:0] sc, input int k, input logic [NUM-1:0] stc,
                            input int delay, input bit tmo);
        int   n;
        exp_t e;
        logic [31:0] r;
        arm_and_clear();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1 iFFStart = sc; n = cyc;
        if (tmo) begin
            e.sf = 0; e.pf = 0; e.co = MAXC; e.to = 1; e.vcyc = -1;
        end else begin
            e.sf = $countones(sc); e.pf = NUM - $countones(stc); e.co = k; e.to = 0;
            e.vcyc = n + k + GROUPS + 1;
        end
        sb.push_back(e);
        if (tmo) begin
            @(posedge clk); #1 iFFStart = '0; iFFStop = '1;
        end else begin
            for (int j = 1; j <= k; j++) begin
                @(posedge clk); #1;
                r = $urandom;
                iFFStart = '0;
                iFFStop  = (j < k) ? (r[NUM-1:0] | 12'h001) : stc;
                iArm     = (j < k) ? r[31] : 1'b0;
            end
            @(posedge clk); #1 iFFStop = '0; iArm = 1'b0;
        end
        wait_valid();
        accept(delay);
        iFFStop = '0;
    endtask

    initial begin
        logic [31:0] r1, r2;
        iRst = 1'b1; iArm = 1'b0; iFFStart = '0; iFFStop = '0; rd.iReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", oBusy, 0);
        check("rst_fine_rst", oFineRst, 0);
        check("rst_enables", {oStartEnable, oStopEnable}, 0);
        check("rst_valid", rd.oValid, 0);
        check("rst_result", {rd.oStartFine, rd.oStopFine, rd.oCoarse, rd.oTimeout}, 0);
        @(posedge clk); #1 iRst = 1'b0;

        run_meas(12'h03F, 5, 12'hFF0, 0, 0);
        run_meas(12'h1FF, 7, 12'hFC0, 10, 0);
        run_meas(12'hFFF, 1, 12'h000, 2, 0);
        run_meas(12'h00F, 0, 12'hFFF, 1, 1);

        arm_and_clear();
        @(posedge clk); #1 iFFStart = 12'h007;
        @(posedge clk); #1 iFFStart = '0; iFFStop = '1;
        repeat (3) @(posedge clk);
        #1 iRst = 1'b1;
        @(posedge clk); #1 iRst = 1'b0; iFFStop = '0;
        @(negedge clk);
        check("midrst_busy", oBusy, 0);
        check("midrst_stop_en", oStopEnable, 0);
        check("midrst_ctrl", {oFineRst, oStartEnable, rd.oValid}, 0);
        check("midrst_result", {rd.oStartFine, rd.oStopFine, rd.oCoarse, rd.oTimeout}, 0);

        for (int i = 0; i < 8; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            run_meas(r1[NUM-1:0] | 12'h001, $urandom_range(1, MAXC - 1),
                     r2[NUM-1:0] & 12'hFFE, $urandom_range(0, 5), 0);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
